// File: rtl/bcd_to_bin_unit_if.sv
// Handshake bundle for bcd_to_bin_unit: packed-BCD request side and binary result side.
// The producer/consumer uses the master modport; the converter uses the slave modport.
interface bcd_to_bin_unit_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );
endinterface

// File: rtl/bcd_to_bin_unit.sv
// Iterative packed-BCD to binary converter (reverse double-dabble, one shift per clock).
// Define BCD2BIN_ERR_CHECK_EN to flag inputs with a nibble above 9 instead of converting them.
module bcd_to_bin_unit #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input logic             clk,
  input logic             reset_n,
  bcd_to_bin_unit_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_shifted;
  logic [SR_W-1:0]   sr_step;
  logic [CNT_W-1:0]  count;
  logic              err_pending;
  logic [BIN_W-1:0]  out_bin_q;
  logic              out_err_q;
  logic              accept;
  logic              bad_digit;

  function automatic logic has_bad_nibble(input logic [BCD_W-1:0] value);
    has_bad_nibble = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (value[4*d +: 4] > 4'd9) has_bad_nibble = 1'b1;
    end
  endfunction

  assign accept = bus.in_valid && (state == IDLE);

`ifdef BCD2BIN_ERR_CHECK_EN
  assign bad_digit = has_bad_nibble(bus.in_bcd);
`else
  assign bad_digit = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;

  // One reverse double-dabble step: shift right, then pull 3 out of any digit that reached 8.
  always_comb begin
    sr_shifted = sr >> 1;
    sr_step    = sr_shifted;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_shifted[BIN_W + 4*d + 3]) begin
        sr_step[BIN_W + 4*d +: 4] = sr_shifted[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = CONV;
      CONV:    if (err_pending || (count == LAST_STEP)) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rejected input still spends one cycle in CONV so the error result lands one edge after accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr          <= '0;
      count       <= '0;
      err_pending <= 1'b0;
      out_bin_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr          <= {bus.in_bcd, {BIN_W{1'b0}}};
            count       <= '0;
            err_pending <= bad_digit;
            out_err_q   <= 1'b0;
          end
        end
        CONV: begin
          if (err_pending) begin
            out_bin_q   <= '0;
            out_err_q   <= 1'b1;
            err_pending <= 1'b0;
          end else begin
            sr    <= sr_step;
            count <= count + 1'b1;
            if (count == LAST_STEP) out_bin_q <= sr_step[BIN_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  logic input_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      input_ok <= 1'b0;
    end else if (accept) begin
      input_ok <= !has_bad_nibble(bus.in_bcd);
    end
  end

  // A well-formed BCD value must have drained completely out of the decimal field by the last step.
  always_ff @(posedge clk) begin
    if (reset_n && (state == CONV) && !err_pending && (count == LAST_STEP) && input_ok) begin
      assert (sr_step[SR_W-1:BIN_W] == '0);
    end
  end
`endif
endmodule

// File: tb/tb_bcd_to_bin_unit.sv
// Self-checking bench for bcd_to_bin_unit: a 4-digit and a 2-digit instance, table vectors,
// hand-written reset/hold sequences and random values checked against a decimal-arithmetic model.
module tb_bcd_to_bin_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  bcd_to_bin_unit_if #(.DIGITS(4), .BIN_W(14)) bus_a ();
  bcd_to_bin_unit_if #(.DIGITS(2), .BIN_W(7))  bus_b ();

  bcd_to_bin_unit #(.DIGITS(4), .BIN_W(14)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  bcd_to_bin_unit #(.DIGITS(2), .BIN_W(7)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal value of the digits with ordinary arithmetic, plus the error rules.
  function automatic void model(input logic [31:0] bcd, input int digits, input int bin_w,
                                output logic [31:0] exp_bin, output logic exp_err,
                                output int exp_lat, output bit bin_known);
    int value = 0;
    bit ok = 1'b1;
    for (int d = digits - 1; d >= 0; d--) begin
      int nib = int'((bcd >> (4 * d)) & 32'hF);
      if (nib > 9) ok = 1'b0;
      value = value * 10 + nib;
    end
    exp_bin   = 32'(value);
    exp_err   = 1'b0;
    exp_lat   = bin_w;
    bin_known = ok;
`ifdef BCD2BIN_ERR_CHECK_EN
    if (!ok) begin
      exp_bin   = 32'd0;
      exp_err   = 1'b1;
      exp_lat   = 1;
      bin_known = 1'b1;
    end
`endif
  endfunction

  task automatic applyStimulus(input logic [15:0] bcd, input int hold, input logic [31:0] exp_bin,
                               input logic exp_err, input int exp_lat, input bit bin_known,
                               input string name);
    int k;
    check({name, " in_ready idle"}, 32'(bus_a.in_ready), 32'd1);
    bus_a.in_bcd    = bcd;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_bcd   = 16'($urandom);
    k = 0;
    while (!bus_a.out_valid && k < 200) begin
      check({name, " in_ready busy"}, 32'(bus_a.in_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(exp_lat));
    if (bin_known) check({name, " out_bin"}, 32'(bus_a.out_bin), exp_bin);
    check({name, " out_err"}, 32'(bus_a.out_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      bus_a.in_valid = i[0];
      bus_a.in_bcd   = 16'($urandom);
      @(negedge clk);
      check({name, " hold out_valid"}, 32'(bus_a.out_valid), 32'd1);
      if (bin_known) check({name, " hold out_bin"}, 32'(bus_a.out_bin), exp_bin);
      check({name, " hold out_err"}, 32'(bus_a.out_err), 32'(exp_err));
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    check({name, " out_valid taken"}, 32'(bus_a.out_valid), 32'd0);
    check({name, " in_ready after take"}, 32'(bus_a.in_ready), 32'd1);
  endtask

  task automatic checkOutput(input logic [7:0] bcd, input string name);
    logic [31:0] eb;
    logic        ee;
    int          el;
    bit          known;
    int          k;
    model(32'(bcd), 2, 7, eb, ee, el, known);
    bus_b.in_bcd    = bcd;
    bus_b.in_valid  = 1'b1;
    bus_b.out_ready = 1'b0;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    k = 0;
    while (!bus_b.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(el));
    if (known) check({name, " out_bin"}, 32'(bus_b.out_bin), eb);
    check({name, " out_err"}, 32'(bus_b.out_err), 32'(ee));
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.out_ready = 1'b0;
    check({name, " in_ready after take"}, 32'(bus_b.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] eb;
    logic        ee;
    int          el;
    bit          known;
    logic [15:0] r;
    int          k;

    vecs.push_back('{16'h9999, 14'h270F, 0});
    vecs.push_back('{16'h0000, 14'h0000, 0});
    vecs.push_back('{16'h0010, 14'h000A, 0});
    vecs.push_back('{16'h1234, 14'h04D2, 20});
    vecs.push_back('{16'h0001, 14'h0001, 0});
    vecs.push_back('{16'h5000, 14'h1388, 2});
    vecs.push_back('{16'h0909, 14'h038D, 0});
    vecs.push_back('{16'h8080, 14'h1F90, 0});

    bus_a.in_valid = 1'b0; bus_a.in_bcd = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_bcd = '0; bus_b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset a in_ready", 32'(bus_a.in_ready), 32'd1);
    check("reset a out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset a out_bin", 32'(bus_a.out_bin), 32'd0);
    check("reset a out_err", 32'(bus_a.out_err), 32'd0);
    check("reset b in_ready", 32'(bus_b.in_ready), 32'd1);
    check("reset b out_valid", 32'(bus_b.out_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].bcd, vecs[i].hold, 32'(vecs[i].bin), 1'b0, 14, 1'b1,
                    $sformatf("vec%0d", i));
    end

    model(32'h1A00, 4, 14, eb, ee, el, known);
    applyStimulus(16'h1A00, 3, eb, ee, el, known, "bad nibble");

    // Abort mid-conversion with reset, then make sure nothing stale survives.
    bus_a.in_bcd = 16'h5678; bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset mid-conv out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset mid-conv in_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0001, 0, 32'd1, 1'b0, 14, 1'b1, "after reset");

    // Reset while a result is waiting in DONE.
    bus_a.in_bcd = 16'h4321; bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    k = 0;
    while (!bus_a.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("pending result", 32'(bus_a.out_bin), 32'd4321);
    reset_n = 1'b0;
    #1;
    check("reset in done out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset in done out_bin", 32'(bus_a.out_bin), 32'd0);
    check("reset in done in_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      r = '0;
      for (int d = 0; d < 4; d++) r[4*d +: 4] = 4'($urandom_range(9, 0));
      model(32'(r), 4, 14, eb, ee, el, known);
      applyStimulus(r, int'($urandom_range(2, 0)), eb, ee, el, known, $sformatf("rand %04h", r));
    end
    for (int i = 0; i < 5; i++) begin
      r = 16'($urandom);
      model(32'(r), 4, 14, eb, ee, el, known);
      applyStimulus(r, 1, eb, ee, el, known, $sformatf("rand any %04h", r));
    end

    checkOutput(8'h99, "b max");
    checkOutput(8'h00, "b zero");
    for (int i = 0; i < 10; i++) begin
      logic [7:0] rb;
      rb[3:0] = 4'($urandom_range(9, 0));
      rb[7:4] = 4'($urandom_range(9, 0));
      checkOutput(rb, $sformatf("b rand %02h", rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
